svc_rv_sram_arb: RTL and testbench

SVC_RV_SRAM_ARB -- requirements
Module: svc_rv_sram_arb

---
 rtl/svc_rv_sram_arb_if.sv | 48 ++++
 rtl/svc_rv_sram_arb.sv | 93 +++++++++
 tb/tb_svc_rv_sram_arb.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/svc_rv_sram_arb_if.sv
// Fetch, data and SRAM bus bundle for the fetch/data single-port SRAM arbiter.
interface svc_rv_sram_arb_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
);
  // Fetch requester
  logic            i_req_valid;
  logic            i_req_ready;
  logic [AW-1:0]   i_req_addr;
  logic            i_rsp_valid;
  logic [DW-1:0]   i_rsp_data;
  // Data requester
  logic            d_req_valid;
  logic            d_req_ready;
  logic [AW-1:0]   d_req_addr;
  logic            d_req_wen;
  logic [DW-1:0]   d_req_wdata;
  logic [DW/8-1:0] d_req_wstrb;
  logic            d_rsp_valid;
  logic [DW-1:0]   d_rsp_data;
  // SRAM macro
  logic            sram_en;
  logic            sram_wen;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_wdata;
  logic [DW/8-1:0] sram_wstrb;
  logic [DW-1:0]   sram_rdata;

  // Arbiter side
  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_rsp_valid, i_rsp_data,
    input  d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wstrb,
    output d_req_ready, d_rsp_valid, d_rsp_data,
    output sram_en, sram_wen, sram_addr, sram_wdata, sram_wstrb,
    input  sram_rdata
  );

  // Requester/SRAM environment side
  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_rsp_valid, i_rsp_data,
    output d_req_valid, d_req_addr, d_req_wen, d_req_wdata, d_req_wstrb,
    input  d_req_ready, d_rsp_valid, d_rsp_data,
    input  sram_en, sram_wen, sram_addr, sram_wdata, sram_wstrb,
    output sram_rdata
  );
endinterface

// File: rtl/svc_rv_sram_arb.sv
// Fetch/data arbiter for a single-port SRAM. Data has priority; fetch wins after
// MAX_WAIT consecutive denied cycles. Read responses return one cycle after grant.
module svc_rv_sram_arb #(
  parameter int unsigned AW       = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic              clk,
  input logic              rst_n,
  svc_rv_sram_arb_if.slave bus
);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {OwnNone, OwnFetch, OwnData} owner_e;

  owner_e          owner_q, owner_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            starve;
  logic            i_ready, d_ready;
  logic            grant_i, grant_d;
  logic [AW-1:0]   addr_sel;
  logic [DW/8-1:0] strb_sel;

  // Arbitration: readies are combinational from valids and the starvation count.
  always_comb begin
    i_ready = 1'b0;
    d_ready = 1'b0;
    starve  = bus.i_req_valid && (wait_q == WW'(MAX_WAIT));
    if (rst_n) begin
      if (starve) begin
        i_ready = 1'b1;
      end else if (bus.d_req_valid) begin
        d_ready = 1'b1;
      end else begin
        i_ready = bus.i_req_valid;
      end
    end
    grant_i = bus.i_req_valid && i_ready;
    grant_d = bus.d_req_valid && d_ready;
  end

  // Next-state: saturating starvation counter and response owner.
  always_comb begin
    wait_d  = wait_q;
    owner_d = OwnNone;
    if (grant_i || !bus.i_req_valid) begin
      wait_d = '0;
    end else if (wait_q != WW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
    if (grant_i) begin
      owner_d = OwnFetch;
    end else if (grant_d && !bus.d_req_wen) begin
      owner_d = OwnData;
    end
  end

  // State register; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OwnNone;
      wait_q  <= '0;
    end else begin
      owner_q <= owner_d;
      wait_q  <= wait_d;
    end
  end

  // SRAM drive from the granted request, zero latency.
  always_comb begin
    addr_sel = grant_d ? bus.d_req_addr : bus.i_req_addr;
    strb_sel = grant_d ? bus.d_req_wstrb : '0;
    bus.i_req_ready = i_ready;
    bus.d_req_ready = d_ready;
    bus.sram_en     = grant_i || grant_d;
    bus.sram_wen    = grant_d && bus.d_req_wen;
    bus.sram_addr   = addr_sel;
    bus.sram_wdata  = bus.d_req_wdata;
    bus.sram_wstrb  = strb_sel;
  end

  // Response routing; data outputs are zero whenever their valid is low.
  always_comb begin
    bus.i_rsp_valid = (owner_q == OwnFetch);
    bus.d_rsp_valid = (owner_q == OwnData);
    bus.i_rsp_data  = (owner_q == OwnFetch) ? bus.sram_rdata : '0;
    bus.d_rsp_data  = (owner_q == OwnData) ? bus.sram_rdata : '0;
  end

  if (MAX_WAIT < 1) begin : g_bad_param
    $error("MAX_WAIT must be at least 1");
  end
endmodule

// File: tb/tb_svc_rv_sram_arb.sv
// Directed bench for svc_rv_sram_arb with a behavioural one-cycle-latency SRAM.
module tb_svc_rv_sram_arb;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  svc_rv_sram_arb_if #(.AW(AW), .DW(DW)) bus ();

  svc_rv_sram_arb #(.AW(AW), .DW(DW), .MAX_WAIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: preloaded on the first edge, byte-strobed writes, registered reads.
  logic [DW-1:0] mem [1024];
  bit loaded = 1'b0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 1024; a++) mem[a] <= 32'hC0DE_0000 | 32'(a);
      mem[16] <= 32'h0000_0013;
      mem[33] <= 32'h1122_3344;
      loaded  <= 1'b1;
    end else if (bus.sram_en) begin
      if (bus.sram_wen) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wstrb[b]) mem[bus.sram_addr][b*8 +: 8] <= bus.sram_wdata[b*8 +: 8];
      end else begin
        bus.sram_rdata <= mem[bus.sram_addr];
      end
    end
  end

  function automatic logic [31:0] exp_word(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input logic iv, input int ia, input logic dv, input int da,
                         input logic wen, input logic [31:0] wd, input logic [3:0] st);
    bus.i_req_valid = iv;
    bus.i_req_addr  = AW'(ia);
    bus.d_req_valid = dv;
    bus.d_req_addr  = AW'(da);
    bus.d_req_wen   = wen;
    bus.d_req_wdata = wd;
    bus.d_req_wstrb = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic iv, input logic dv, input logic [31:0] d);
    chk({tag, "_i_rsp_valid"}, 32'(bus.i_rsp_valid), 32'(iv));
    chk({tag, "_d_rsp_valid"}, 32'(bus.d_rsp_valid), 32'(dv));
    chk({tag, "_i_rsp_data"}, bus.i_rsp_data, iv ? d : 32'h0);
    chk({tag, "_d_rsp_data"}, bus.d_rsp_data, dv ? d : 32'h0);
  endtask

  initial begin
    logic fetch_turn;
    bus.sram_rdata = '0;
    // Requests during reset are never accepted.
    set_req(1'b1, 'h10, 1'b1, 'h20, 1'b0, 32'h0, 4'h0);
    #2;
    chk("rst_i_ready", 32'(bus.i_req_ready), 32'd0);
    chk("rst_d_ready", 32'(bus.d_req_ready), 32'd0);
    chk("rst_sram_en", 32'(bus.sram_en), 32'd0);
    chk_rsp("rst", 1'b0, 1'b0, 32'h0);
    tick(); tick(); tick();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    rst_n = 1'b1;
    tick();

    // Fetch only.
    set_req(1'b1, 'h10, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    #1;
    chk("f_i_ready", 32'(bus.i_req_ready), 32'd1);
    chk("f_d_ready", 32'(bus.d_req_ready), 32'd0);
    chk("f_sram_en", 32'(bus.sram_en), 32'd1);
    chk("f_sram_addr", 32'(bus.sram_addr), 32'h10);
    chk("f_sram_wen", 32'(bus.sram_wen), 32'd0);
    tick();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    chk_rsp("f_rsp", 1'b1, 1'b0, 32'h0000_0013);
    tick();
    chk_rsp("f_idle", 1'b0, 1'b0, 32'h0);

    // Full write then read back.
    set_req(1'b0, 0, 1'b1, 'h20, 1'b1, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk("w_d_ready", 32'(bus.d_req_ready), 32'd1);
    chk("w_sram_wen", 32'(bus.sram_wen), 32'd1);
    chk("w_sram_wstrb", 32'(bus.sram_wstrb), 32'hF);
    tick();
    set_req(1'b0, 0, 1'b1, 'h20, 1'b0, 32'h0, 4'h0);
    chk_rsp("w_norsp", 1'b0, 1'b0, 32'h0);
    tick();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    chk_rsp("w_rd", 1'b0, 1'b1, 32'hDEAD_BEEF);

    // Partial write of the low two bytes.
    set_req(1'b0, 0, 1'b1, 'h21, 1'b1, 32'hAABB_CCDD, 4'h3);
    tick();
    set_req(1'b0, 0, 1'b1, 'h21, 1'b0, 32'h0, 4'h0);
    chk_rsp("pw_norsp", 1'b0, 1'b0, 32'h0);
    tick();
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    chk_rsp("pw_rd", 1'b0, 1'b1, 32'h1122_CCDD);
    tick();
    chk("idle_sram_en", 32'(bus.sram_en), 32'd0);
    chk("idle_sram_wstrb", 32'(bus.sram_wstrb), 32'h0);

    // Contention: data wins four cycles, fetch the fifth, repeating.
    for (int k = 0; k < 15; k++) begin
      set_req(1'b1, 'h40, 1'b1, 'h50 + k, 1'b0, 32'h0, 4'h0);
      #1;
      fetch_turn = ((k % 5) == 4);
      chk("c_i_ready", 32'(bus.i_req_ready), 32'(fetch_turn));
      chk("c_d_ready", 32'(bus.d_req_ready), 32'(!fetch_turn));
      chk("c_sram_addr", 32'(bus.sram_addr), fetch_turn ? 32'h40 : 32'('h50 + k));
      tick();
      if (fetch_turn) chk_rsp("c_rsp_f", 1'b1, 1'b0, exp_word('h40));
      else chk_rsp("c_rsp_d", 1'b0, 1'b1, exp_word('h50 + k));
    end
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    tick();

    // Reset right after a fetch is accepted: the response is dropped.
    set_req(1'b1, 'h10, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    #1;
    chk("rm_i_ready", 32'(bus.i_req_ready), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rm_async_i_ready", 32'(bus.i_req_ready), 32'd0);
    chk("rm_async_sram_en", 32'(bus.sram_en), 32'd0);
    tick();
    chk_rsp("rm_in_rst", 1'b0, 1'b0, 32'h0);
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    rst_n = 1'b1;
    tick();
    chk_rsp("rm_after1", 1'b0, 1'b0, 32'h0);
    tick();
    chk_rsp("rm_after2", 1'b0, 1'b0, 32'h0);

    // Build up starvation count to 3, reset, and confirm it restarts from zero.
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 'h40, 1'b1, 'h60, 1'b0, 32'h0, 4'h0);
      #1;
      chk("ws_d_ready", 32'(bus.d_req_ready), 32'd1);
      tick();
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("ws_rst_d_ready", 32'(bus.d_req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("ws_post_i_ready", 32'(bus.i_req_ready), 32'(k == 4));
      chk("ws_post_d_ready", 32'(bus.d_req_ready), 32'(k != 4));
      tick();
    end
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    tick();

    // Back-to-back alternating fetch/data reads.
    for (int k = 0; k < 16; k++) begin
      if ((k % 2) == 0) set_req(1'b1, 'h100 + k, 1'b0, 0, 1'b0, 32'h0, 4'h0);
      else set_req(1'b0, 0, 1'b1, 'h200 + k, 1'b0, 32'h0, 4'h0);
      #1;
      chk("t_sram_en", 32'(bus.sram_en), 32'd1);
      chk("t_sram_addr", 32'(bus.sram_addr), ((k % 2) == 0) ? 32'('h100 + k) : 32'('h200 + k));
      tick();
      if ((k % 2) == 0) chk_rsp("t_rsp_f", 1'b1, 1'b0, exp_word('h100 + k));
      else chk_rsp("t_rsp_d", 1'b0, 1'b1, exp_word('h200 + k));
    end
    set_req(1'b0, 0, 1'b0, 0, 1'b0, 32'h0, 4'h0);
    tick();
    chk_rsp("t_end", 1'b0, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
